// File: rtl/cache_refill_unit.sv
// Miss handler for a 4-way cache with 64-byte lines: fetches the line beat by beat,
// merges store data into the fill stream, extracts load data and answers the LSQ.
module cache_refill_unit #(
    parameter int         LINE_BEATS = 16,
    parameter logic [3:0] LFSR_SEED  = 4'b1011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_valid,
    output logic        miss_ready,
    input  logic [31:0] miss_addr,
    input  logic        miss_is_store,
    input  logic        miss_size,
    input  logic [31:0] miss_wdata,
    input  logic [3:0]  way_valid,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        fill_we,
    output logic [1:0]  fill_way,
    output logic [6:0]  fill_index,
    output logic [3:0]  fill_word,
    output logic [31:0] fill_wdata,
    output logic        fill_commit,
    output logic [18:0] fill_tag,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    localparam logic [3:0] LAST_BEAT = 4'(LINE_BEATS - 1);

    typedef enum logic [2:0] {IDLE, REQ, FILL, COMMIT, RESP} state_t;

    state_t      state;
    logic [3:0]  beat;
    logic [3:0]  lfsr;
    logic [5:0]  off_p0;
    logic        store_p0;
    logic        byte_p0;
    logic [15:0] wdata_p0;
    logic [18:0] tag_p0;
    logic [7:0]  lo_byte;
    logic [7:0]  hi_byte;
    logic [5:0]  off_hi;
    logic [1:0]  way_sel;
    logic        misaligned;
    logic        unused_wdata;

    assign off_hi       = off_p0 + 6'd1;
    assign misaligned   = !miss_size && (miss_addr[5:0] == 6'd63);
    assign unused_wdata = ^miss_wdata[31:16];

    // Prefer an empty way; only evict pseudo-randomly when the set is full.
    always_comb begin
        way_sel = lfsr[1:0];
        if (!way_valid[0])      way_sel = 2'd0;
        else if (!way_valid[1]) way_sel = 2'd1;
        else if (!way_valid[2]) way_sel = 2'd2;
        else if (!way_valid[3]) way_sel = 2'd3;
    end

    function automatic logic [3:0] lfsr_next(input logic [3:0] cur);
        return {cur[2:0], cur[3] ^ cur[2]};
    endfunction

    // Overlay store byte(s) onto a beat; a halfword may land in two adjacent beats.
    function automatic logic [31:0] merge_beat(input logic [31:0] data, input logic [3:0] k,
                                               input logic [5:0] lo, input logic [5:0] hi,
                                               input logic is_store, input logic is_byte,
                                               input logic [15:0] wd);
        logic [31:0] merged;
        merged = data;
        if (is_store && lo[5:2] == k)
            merged[{lo[1:0], 3'b000} +: 8] = wd[7:0];
        if (is_store && !is_byte && hi[5:2] == k)
            merged[{hi[1:0], 3'b000} +: 8] = wd[15:8];
        return merged;
    endfunction

    function automatic logic [31:0] load_result(input logic is_store, input logic is_byte,
                                                input logic [7:0] lo, input logic [7:0] hi);
        if (is_store) return 32'd0;
        if (is_byte)  return {24'd0, lo};
        return {16'd0, hi, lo};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            beat          <= 4'd0;
            lfsr          <= LFSR_SEED;
            off_p0        <= 6'd0;
            store_p0      <= 1'b0;
            byte_p0       <= 1'b0;
            wdata_p0      <= 16'd0;
            tag_p0        <= 19'd0;
            lo_byte       <= 8'd0;
            hi_byte       <= 8'd0;
            miss_ready    <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= 32'd0;
            fill_we       <= 1'b0;
            fill_way      <= 2'd0;
            fill_index    <= 7'd0;
            fill_word     <= 4'd0;
            fill_wdata    <= 32'd0;
            fill_commit   <= 1'b0;
            fill_tag      <= 19'd0;
            resp_valid    <= 1'b0;
            resp_data     <= 32'd0;
            resp_err      <= 1'b0;
        end else begin
            fill_we     <= 1'b0;
            fill_commit <= 1'b0;
            case (state)
                // Acceptance: snapshot the miss and pick the victim way.
                IDLE: begin
                    if (miss_valid) begin
                        miss_ready <= 1'b0;
                        off_p0     <= miss_addr[5:0];
                        store_p0   <= miss_is_store;
                        byte_p0    <= miss_size;
                        wdata_p0   <= miss_wdata[15:0];
                        tag_p0     <= miss_addr[31:13];
                        fill_index <= miss_addr[12:6];
                        fill_way   <= way_sel;
                        lo_byte    <= 8'd0;
                        hi_byte    <= 8'd0;
                        if (misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= 32'd0;
                        end else begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {miss_addr[31:6], 6'd0};
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        beat          <= 4'd0;
                        state         <= FILL;
                    end
                end
                // Fill stage: one registered cache write per accepted beat.
                FILL: begin
                    if (mem_resp_valid) begin
                        fill_we    <= 1'b1;
                        fill_word  <= beat;
                        fill_wdata <= merge_beat(mem_resp_data, beat, off_p0, off_hi,
                                                 store_p0, byte_p0, wdata_p0);
                        if (off_p0[5:2] == beat)
                            lo_byte <= mem_resp_data[{off_p0[1:0], 3'b000} +: 8];
                        if (off_hi[5:2] == beat)
                            hi_byte <= mem_resp_data[{off_hi[1:0], 3'b000} +: 8];
                        beat <= beat + 4'd1;
                        if (beat == LAST_BEAT)
                            state <= COMMIT;
                    end
                end
                COMMIT: begin
                    fill_commit <= 1'b1;
                    fill_tag    <= tag_p0;
                    lfsr        <= lfsr_next(lfsr);
                    resp_valid  <= 1'b1;
                    resp_err    <= 1'b0;
                    resp_data   <= load_result(store_p0, byte_p0, lo_byte, hi_byte);
                    state       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_data  <= 32'd0;
                        miss_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_unit.sv
// Bench for cache_refill_unit: directed scenarios plus randomized misses checked
// against a byte-array model of the line and a per-cycle output monitor.
module tb_cache_refill_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid, miss_ready, miss_is_store, miss_size;
    logic [31:0] miss_addr, miss_wdata;
    logic [3:0]  way_valid;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_resp_data;
    logic        fill_we, fill_commit;
    logic [1:0]  fill_way;
    logic [6:0]  fill_index;
    logic [3:0]  fill_word;
    logic [31:0] fill_wdata;
    logic [18:0] fill_tag;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_data;

    cache_refill_unit #(.LINE_BEATS(16), .LFSR_SEED(4'b1011)) dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .miss_is_store(miss_is_store), .miss_size(miss_size), .miss_wdata(miss_wdata),
        .way_valid(way_valid),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .fill_we(fill_we), .fill_way(fill_way), .fill_index(fill_index), .fill_word(fill_word),
        .fill_wdata(fill_wdata), .fill_commit(fill_commit), .fill_tag(fill_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model expectations for the transaction in flight
    logic [3:0]  lfsr_m;
    logic [31:0] exp_addr, exp_rdata;
    logic [31:0] exp_words [16];
    logic [1:0]  exp_way;
    logic [6:0]  exp_index;
    logic [18:0] exp_tag;
    logic        exp_err;
    int          fill_cnt, commit_cnt, memreq_cnt;
    logic [31:0] obs_addr, obs_w0, obs_w1, obs_rdata, obs_way, obs_index, obs_tag, obs_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] lfsr_step(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    // Per-cycle monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (fill_we && fill_commit) check("we_with_commit", 32'd1, 32'd0);
            if (fill_we) begin
                check("fill_word", 32'(fill_word), 32'(fill_cnt));
                check("fill_way", 32'(fill_way), 32'(exp_way));
                check("fill_index", 32'(fill_index), 32'(exp_index));
                check("fill_wdata", fill_wdata, exp_words[fill_word]);
                if (fill_word == 4'd0) obs_w0 = fill_wdata;
                if (fill_word == 4'd1) obs_w1 = fill_wdata;
                fill_cnt++;
            end
            if (fill_commit) begin
                check("commit_tag", 32'(fill_tag), 32'(exp_tag));
                check("commit_way", 32'(fill_way), 32'(exp_way));
                check("commit_after_16", 32'(fill_cnt), 32'd16);
                obs_way = 32'(fill_way); obs_index = 32'(fill_index); obs_tag = 32'(fill_tag);
                commit_cnt++;
            end
            if (mem_req_valid) begin
                check("mem_req_addr", mem_req_addr, exp_addr);
                obs_addr = mem_req_addr;
                memreq_cnt++;
            end
            if (resp_valid) begin
                check("resp_data", resp_data, exp_rdata);
                check("resp_err", 32'(resp_err), 32'(exp_err));
                obs_rdata = resp_data; obs_err = 32'(resp_err);
            end
        end
    end

    task automatic do_miss(input logic [31:0] addr, input logic st, input logic sz,
                           input logic [31:0] wd, input logic [3:0] wv,
                           input int req_dly, input int resp_dly,
                           input bit directed, input bit gaps, input int abort_beat);
        logic [31:0] bt [16];
        logic [7:0]  line [64];
        int off, t;
        bit err, found;
        off = int'(addr[5:0]);
        err = (sz == 1'b0) && (off == 63);
        for (int k = 0; k < 16; k++)
            bt[k] = directed ? 32'h03020100 + 32'h04040404 * 32'(k) : $urandom;
        for (int p = 0; p < 64; p++) line[p] = bt[p / 4][8 * (p % 4) +: 8];
        exp_rdata = 32'd0;
        if (!err && !st) exp_rdata = sz ? {24'd0, line[off]} : {16'd0, line[off + 1], line[off]};
        if (st && !err) begin
            line[off] = wd[7:0];
            if (!sz) line[off + 1] = wd[15:8];
        end
        for (int k = 0; k < 16; k++)
            exp_words[k] = {line[4 * k + 3], line[4 * k + 2], line[4 * k + 1], line[4 * k]};
        exp_err = err;
        found = 0;
        for (int i = 0; i < 4; i++)
            if (!found && !wv[i]) begin exp_way = 2'(i); found = 1; end
        if (!found) exp_way = lfsr_m[1:0];
        exp_addr  = {addr[31:6], 6'd0};
        exp_index = addr[12:6];
        exp_tag   = addr[31:13];
        fill_cnt = 0; commit_cnt = 0; memreq_cnt = 0;
        obs_addr = 32'hDEAD0000; obs_w0 = 32'hDEAD0000; obs_w1 = 32'hDEAD0000;
        obs_rdata = 32'hDEAD0000; obs_way = 32'hDEAD0000; obs_index = 32'hDEAD0000;
        obs_tag = 32'hDEAD0000; obs_err = 32'hDEAD0000;

        t = 0;
        while (!miss_ready && t < 50) begin @(negedge clk); t++; end
        check("miss_ready_idle", 32'(miss_ready), 32'd1);
        miss_valid = 1'b1; miss_addr = addr; miss_is_store = st; miss_size = sz;
        miss_wdata = wd; way_valid = wv;
        @(posedge clk);
        #1 miss_valid = 1'b0; way_valid = $urandom;
        @(negedge clk);

        if (err) begin
            if (!resp_valid) @(negedge clk);
            check("err_latency", 32'(resp_valid), 32'd1);
        end else begin
            t = 0;
            while (!mem_req_valid && t < 20) begin @(negedge clk); t++; end
            check("mem_req_seen", 32'(mem_req_valid), 32'd1);
            for (int i = 0; i < req_dly; i++) begin
                mem_resp_valid = 1'b1; mem_resp_data = $urandom;
                @(negedge clk);
            end
            mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            check("mem_req_dropped", 32'(mem_req_valid), 32'd0);
            for (int k = 0; k < 16; k++) begin
                if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
                mem_resp_valid = 1'b1; mem_resp_data = bt[k];
                @(negedge clk);
                mem_resp_valid = 1'b0;
                if (k == abort_beat) begin
                    #2 rst = 1'b1;
                    #1;
                    check("abort_fill_we", 32'(fill_we), 32'd0);
                    check("abort_commit", 32'(fill_commit), 32'd0);
                    check("abort_miss_ready", 32'(miss_ready), 32'd1);
                    check("abort_fill_wdata", fill_wdata, 32'd0);
                    check("abort_fill_word", 32'(fill_word), 32'd0);
                    check("abort_resp_valid", 32'(resp_valid), 32'd0);
                    lfsr_m = 4'b1011;
                    @(negedge clk);
                    rst = 1'b0;
                    check("abort_no_commit", 32'(commit_cnt), 32'd0);
                    check("abort_partial_writes", 32'(fill_cnt), 32'(abort_beat + 1));
                    return;
                end
            end
        end

        t = 0;
        while (!resp_valid && t < 60) begin @(negedge clk); t++; end
        check("resp_seen", 32'(resp_valid), 32'd1);
        for (int i = 0; i < resp_dly; i++) begin
            check("miss_ready_busy", 32'(miss_ready), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        check("miss_ready_handshake", 32'(miss_ready), 32'd0);
        @(negedge clk);
        resp_ready = 1'b0;
        check("miss_ready_after", 32'(miss_ready), 32'd1);
        check("resp_dropped", 32'(resp_valid), 32'd0);
        if (!err) begin
            check("commit_count", 32'(commit_cnt), 32'd1);
            check("fill_count", 32'(fill_cnt), 32'd16);
            check("req_hold_cycles", 32'(memreq_cnt), 32'(req_dly + 1));
            lfsr_m = lfsr_step(lfsr_m);
        end else begin
            check("err_no_req", 32'(memreq_cnt), 32'd0);
            check("err_no_fill", 32'(fill_cnt), 32'd0);
            check("err_no_commit", 32'(commit_cnt), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst = 1'b1; miss_valid = 1'b0; miss_addr = 32'd0; miss_is_store = 1'b0;
        miss_size = 1'b0; miss_wdata = 32'd0; way_valid = 4'd0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = 32'd0; resp_ready = 1'b0;
        lfsr_m = 4'b1011;
        repeat (2) @(negedge clk);
        check("rst_miss_ready", 32'(miss_ready), 32'd1);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_mem_req_addr", mem_req_addr, 32'd0);
        check("rst_fill_we", 32'(fill_we), 32'd0);
        check("rst_fill_commit", 32'(fill_commit), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full sets: victim follows the LFSR from its seed
        do_miss(32'h1234_5008, 1'b0, 1'b1, 32'd0, 4'b1111, 0, 0, 1'b1, 1'b0, -1);
        check("lfsr_way_first", obs_way, 32'd3);
        do_miss(32'h8000_1110, 1'b0, 1'b0, 32'd0, 4'b1111, 1, 0, 1'b1, 1'b0, -1);
        check("lfsr_way_second", obs_way, 32'd3);

        do_miss(32'h0000_2045, 1'b0, 1'b1, 32'd0, 4'b0000, 0, 0, 1'b1, 1'b0, -1);
        check("lit_mem_req_addr", obs_addr, 32'h0000_2040);
        check("lit_way0", obs_way, 32'd0);
        check("lit_index1", obs_index, 32'd1);
        check("lit_tag1", obs_tag, 32'd1);
        check("lit_load_byte", obs_rdata, 32'h0000_0005);

        do_miss(32'h0000_4003, 1'b1, 1'b0, 32'h0000_BEEF, 4'b0001, 0, 0, 1'b1, 1'b0, -1);
        check("lit_store_w0", obs_w0, 32'hEF02_0100);
        check("lit_store_w1", obs_w1, 32'h0706_05BE);
        check("lit_store_resp", obs_rdata, 32'd0);

        do_miss(32'h0000_6000, 1'b0, 1'b0, 32'd0, 4'b1011, 0, 0, 1'b1, 1'b0, -1);
        check("lit_way2", obs_way, 32'd2);

        do_miss(32'h0000_807F, 1'b0, 1'b0, 32'd0, 4'b0000, 0, 0, 1'b1, 1'b0, -1);
        check("lit_misaligned_err", obs_err, 32'd1);

        do_miss(32'hABCD_E112, 1'b0, 1'b0, 32'd0, 4'b0011, 5, 3, 1'b0, 1'b1, -1);

        do_miss(32'h0000_A010, 1'b1, 1'b1, 32'h0000_0077, 4'b1111, 0, 0, 1'b1, 1'b0, 7);
        do_miss(32'h0000_C020, 1'b0, 1'b1, 32'd0, 4'b1111, 0, 0, 1'b1, 1'b0, -1);
        check("lit_way_after_reset", obs_way, 32'd3);

        for (int n = 0; n < 25; n++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a[5:0] = 6'd63;
            do_miss(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                    ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
